// File: rtl/mux_pkg.sv
// mux_pkg: shared scan state encoding and settle counter width for mux_scan_sampler
package mux_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, VALID} scan_state_t;
  localparam int SETTLE_W = 8;
endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable settle down-counter; done flags the last settle cycle (count 1)
// ports: clk, rst_n (async active-low), load (reload with LOAD), done (count == 1)
module scan_timer import mux_pkg::*; #(
  parameter int LOAD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);
  logic [SETTLE_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= SETTLE_W'(LOAD);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == SETTLE_W'(1);
endmodule

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: round-robin key sequencer that settles an external mux and streams its samples
// ports: clk, rst_n (async active-low); en scan enable; key drives the mux; mux_data is the mux output;
//   out_valid/out_ready/out_key/out_data form the sample stream; wrap pulses after channel NR_KEY-1 completes.
// SCAN_CHANGE_ONLY_EN: when defined, a channel whose data equals its last accepted value is skipped.
module mux_scan_sampler #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2,
  parameter int SETTLE   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic [KEY_LEN-1:0]  key,
  input  logic [DATA_LEN-1:0] mux_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [KEY_LEN-1:0]  out_key,
  output logic [DATA_LEN-1:0] out_data,
  output logic                wrap
);
  import mux_pkg::*;
  localparam logic [KEY_LEN-1:0] LAST_KEY = KEY_LEN'(NR_KEY - 1);
  scan_state_t state, nxt;
  logic done, load, capture, skip, accept, fin;
  scan_timer #(.LOAD(SETTLE)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .done (done)
  );
`ifdef SCAN_CHANGE_ONLY_EN
  logic [DATA_LEN-1:0] last [NR_KEY];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= '{default: '0};
    else if (accept) last[key] <= out_data;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= mux_pkg::IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      mux_pkg::IDLE:   nxt = en ? mux_pkg::SETTLE : mux_pkg::IDLE;
      mux_pkg::SETTLE: nxt = !done ? mux_pkg::SETTLE : !skip ? mux_pkg::VALID : en ? mux_pkg::SETTLE : mux_pkg::IDLE;
      mux_pkg::VALID:  nxt = !out_ready ? mux_pkg::VALID : en ? mux_pkg::SETTLE : mux_pkg::IDLE;
      default:         nxt = mux_pkg::IDLE;
    endcase
  end
  // a channel completes either on accept or, with change-only scanning, on an unchanged sample
  always_comb begin
    capture = state == mux_pkg::SETTLE && done;
    accept  = state == mux_pkg::VALID && out_ready;
`ifdef SCAN_CHANGE_ONLY_EN
    skip = capture && mux_data == last[key];
`else
    skip = 1'b0;
`endif
    fin  = accept || skip;
    load = en && (state == mux_pkg::IDLE || fin);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key       <= '0;
      out_valid <= 1'b0;
      out_key   <= '0;
      out_data  <= '0;
      wrap      <= 1'b0;
    end else begin
      key       <= fin ? (key == LAST_KEY ? '0 : key + 1'b1) : key;
      out_valid <= (capture && !skip) || (out_valid && !accept);
      wrap      <= fin && key == LAST_KEY;
      if (capture && !skip) begin
        out_key  <= key;
        out_data <= mux_data;
      end
    end
endmodule
